tlb: RTL and testbench
======================

TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of entries, a power of two from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have inputs s0_vpn (19), s0_odd (1) and s0_asid (8), forming search port 0 (instruction side).
REQ-005 SHALL have outputs s0_found (1), s0_index ($clog2(TLBNUM)), s0_pfn (20), s0_c (3), s0_d (1) and s0_v (1).
REQ-006 SHALL have search port 1 (data side) with the same signals prefixed s1_.
REQ-007 SHALL have write-port inputs we (1) and w_index ($clog2(TLBNUM)), plus entry fields: w_vpn2 19, w_asid 8, w_g 1, w_pfn0 20, w_c0 3, w_d0 1, w_v0 1, w_pfn1 20, w_c1 3, w_d1 1, w_v1 1.
REQ-008 SHALL have input r_index ($clog2(TLBNUM)) and outputs r_* carrying the same fields as w_*.
REQ-009 SHALL have inputs wired_we (1) and wired ($clog2(TLBNUM)), and output random ($clog2(TLBNUM)).

Function
REQ-010 Search SHALL be combinational, zero latency. An entry hits when:
- entry-valid=1;
- vpn2 == s_vpn;
- g=1 or asid == s_asid.
REQ-011 On multiple hits, the lowest index SHALL win; s_index reports that index.
REQ-012 s_pfn/c/d/v SHALL come from the even half when s_odd=0 and the odd half when s_odd=1.
REQ-013 On a miss, s_found=0 and s_index/pfn/c/d/v SHALL all be 0.
REQ-014 When we=1, entry w_index SHALL be written at the rising edge and its entry-valid bit set.
REQ-015 A search or read of the same index in the same cycle as the write SHALL return the old contents; the new contents are visible from the next cycle.
REQ-016 Read SHALL be combinational: r_* reflect entry r_index.
REQ-017 The stored g SHALL be w_g; r_g returns it.
REQ-018 The random counter SHALL decrement by 1 each cycle.
REQ-019 When random == wired, or random == 0, the next value SHALL be TLBNUM-1.
REQ-020 When wired_we=1, the next random value SHALL be TLBNUM-1, taking priority over decrement and wrap.
REQ-021 A wired value of TLBNUM-1 SHALL hold random at TLBNUM-1 every cycle.
REQ-022 we and wired_we in the same cycle SHALL both take effect independently.

Reset
REQ-023 resetn low SHALL clear every entry-valid bit and all stored fields to 0, set random to TLBNUM-1, and drive all s_* outputs to 0 immediately.
REQ-024 Assertion mid-operation SHALL discard any write in that cycle; the first write honoured is on the first edge with resetn high.

Configuration
REQ-025 Macro TLB_RANDOM_EN SHALL control the random counter.
- Defined: the random counter and wired_we/wired are implemented per REQ-018 to REQ-021.
- Undefined: random is tied to 0, wired_we/wired are ignored, and no counter flops exist.

Structure
REQ-026 A shared package SHALL hold:
- TLBNUM default and index width;
- field widths (VPN2 19, ASID 8, PFN 20, C 3);
- a packed entry typedef.
REQ-027 One sub-module, tlb_match, SHALL be instantiated once per search port: a per-port priority match over all entries giving found, index and selected half.

Verification
REQ-028 After reset, search of vpn 0x00000, asid 0 -> s0_found=0 and s1_found=0; random=15.
REQ-029 Write idx 3: vpn2 0x12345, asid 0x05, g 0, pfn0 0xAAAAA v0 1, pfn1 0xBBBBB v1 0, d1 1. Then search:
- s0 (0x12345, odd 0, asid 0x05) -> found 1, index 3, pfn 0xAAAAA, v 1;
- s1 (odd 1) -> pfn 0xBBBBB, v 0, d 1;
- asid 0x06 -> found 0.
REQ-030 Same vpn2 written at idx 7 with g=1 and at idx 2 with asid 0x09:
- search asid 0x09 -> index 2;
- search asid 0x01 -> index 7.
REQ-031 Write idx 5 while searching its old vpn in the same cycle -> old result that cycle, new result the next cycle.
REQ-032 wired=4 with wired_we pulse, TLBNUM=16 -> random reads 15,14,...,4 then 15 again; wired_we mid-sequence -> next cycle 15.
REQ-033 Build without TLB_RANDOM_EN -> random stays 0 under any wired_we/wired stimulus; search/write scenarios unchanged.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared TLB types and widths: default entry count, field widths and the packed entry layout.
package tlb_pkg;
    localparam int TLBNUM_DEF = 16;
    localparam int IDX_W_DEF  = $clog2(TLBNUM_DEF);
    localparam int VPN2_W     = 19;
    localparam int ASID_W     = 8;
    localparam int PFN_W      = 20;
    localparam int C_W        = 3;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [C_W-1:0]   c;
        logic             d;
        logic             v;
    } tlb_page_t;

    // p0 maps the even page of the pair, p1 the odd page.
    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        tlb_page_t         p0;
        tlb_page_t         p1;
    } tlb_entry_t;
endpackage

// File: rtl/tlb_if.sv
// TLB bus: two search ports, one write port, one read port and the random/wired controls.
interface tlb_if import tlb_pkg::*; #(parameter int TLBNUM = TLBNUM_DEF);
    localparam int IW = $clog2(TLBNUM);

    logic [VPN2_W-1:0] s0_vpn;  logic s0_odd;  logic [ASID_W-1:0] s0_asid;
    logic s0_found; logic [IW-1:0] s0_index; logic [PFN_W-1:0] s0_pfn;
    logic [C_W-1:0] s0_c; logic s0_d; logic s0_v;

    logic [VPN2_W-1:0] s1_vpn;  logic s1_odd;  logic [ASID_W-1:0] s1_asid;
    logic s1_found; logic [IW-1:0] s1_index; logic [PFN_W-1:0] s1_pfn;
    logic [C_W-1:0] s1_c; logic s1_d; logic s1_v;

    logic we; logic [IW-1:0] w_index;
    logic [VPN2_W-1:0] w_vpn2; logic [ASID_W-1:0] w_asid; logic w_g;
    logic [PFN_W-1:0] w_pfn0; logic [C_W-1:0] w_c0; logic w_d0; logic w_v0;
    logic [PFN_W-1:0] w_pfn1; logic [C_W-1:0] w_c1; logic w_d1; logic w_v1;

    logic [IW-1:0] r_index;
    logic [VPN2_W-1:0] r_vpn2; logic [ASID_W-1:0] r_asid; logic r_g;
    logic [PFN_W-1:0] r_pfn0; logic [C_W-1:0] r_c0; logic r_d0; logic r_v0;
    logic [PFN_W-1:0] r_pfn1; logic [C_W-1:0] r_c1; logic r_d1; logic r_v1;

    logic wired_we; logic [IW-1:0] wired; logic [IW-1:0] random;

    modport master (
        output s0_vpn, s0_odd, s0_asid, s1_vpn, s1_odd, s1_asid,
        output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
        output w_pfn1, w_c1, w_d1, w_v1, r_index, wired_we, wired,
        input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        input  r_pfn1, r_c1, r_d1, r_v1, random
    );

    modport slave (
        input  s0_vpn, s0_odd, s0_asid, s1_vpn, s1_odd, s1_asid,
        input  we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
        input  w_pfn1, w_c1, w_d1, w_v1, r_index, wired_we, wired,
        output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        output r_pfn1, r_c1, r_d1, r_v1, random
    );
endinterface

// File: rtl/tlb_match.sv
// One search port: priority match over all entries, lowest index wins; miss returns all zeros.
module tlb_match import tlb_pkg::*; #(
    parameter int  TLBNUM = TLBNUM_DEF,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  tlb_entry_t [TLBNUM-1:0] entries,
    input  logic [TLBNUM-1:0]       valid,
    input  logic [VPN2_W-1:0]       vpn,
    input  logic                    odd,
    input  logic [ASID_W-1:0]       asid,
    output logic                    found,
    output logic [IW-1:0]           index,
    output tlb_page_t               page
);
    logic [TLBNUM-1:0] hit;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_hit
        assign hit[i] = valid[i] && (entries[i].vpn2 == vpn) &&
                        (entries[i].g || (entries[i].asid == asid));
    end

    always_comb begin
        found = |hit;
        index = '0;
        // Scan downwards so the last assignment is the lowest hitting index.
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) index = IW'(i);
        end
        if (!found)   page = '0;
        else if (odd) page = entries[index].p1;
        else          page = entries[index].p0;
    end
endmodule

// File: rtl/tlb.sv
// TLB top: entry array, write/read ports, two search ports and the random replacement counter.
// Macro TLB_RANDOM_EN enables the random counter and wired controls; undefined ties random to 0.
module tlb import tlb_pkg::*; #(
    parameter int TLBNUM = TLBNUM_DEF
) (
    input logic   clk,
    input logic   resetn,
    tlb_if.slave  bus
);
    localparam int IW = $clog2(TLBNUM);

    tlb_entry_t [TLBNUM-1:0] entries;
    logic [TLBNUM-1:0]       valid;
    tlb_entry_t              w_entry;
    tlb_entry_t              r_entry;
    tlb_page_t               page0, page1;

    assign w_entry = '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
                       p0: '{bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0},
                       p1: '{bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1}};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entries <= '0;
            valid   <= '0;
        end else if (bus.we) begin
            entries[bus.w_index] <= w_entry;
            valid[bus.w_index]   <= 1'b1;
        end
    end

    tlb_match #(.TLBNUM(TLBNUM)) u_match0 (
        .entries(entries), .valid(valid), .vpn(bus.s0_vpn), .odd(bus.s0_odd),
        .asid(bus.s0_asid), .found(bus.s0_found), .index(bus.s0_index), .page(page0)
    );

    tlb_match #(.TLBNUM(TLBNUM)) u_match1 (
        .entries(entries), .valid(valid), .vpn(bus.s1_vpn), .odd(bus.s1_odd),
        .asid(bus.s1_asid), .found(bus.s1_found), .index(bus.s1_index), .page(page1)
    );

    assign bus.s0_pfn = page0.pfn;
    assign bus.s0_c   = page0.c;
    assign bus.s0_d   = page0.d;
    assign bus.s0_v   = page0.v;
    assign bus.s1_pfn = page1.pfn;
    assign bus.s1_c   = page1.c;
    assign bus.s1_d   = page1.d;
    assign bus.s1_v   = page1.v;

    assign r_entry    = entries[bus.r_index];
    assign bus.r_vpn2 = r_entry.vpn2;
    assign bus.r_asid = r_entry.asid;
    assign bus.r_g    = r_entry.g;
    assign bus.r_pfn0 = r_entry.p0.pfn;
    assign bus.r_c0   = r_entry.p0.c;
    assign bus.r_d0   = r_entry.p0.d;
    assign bus.r_v0   = r_entry.p0.v;
    assign bus.r_pfn1 = r_entry.p1.pfn;
    assign bus.r_c1   = r_entry.p1.c;
    assign bus.r_d1   = r_entry.p1.d;
    assign bus.r_v1   = r_entry.p1.v;

`ifdef TLB_RANDOM_EN
    localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);
    logic [IW-1:0] rand_q;

    // Counts down through the non-wired region [TLBNUM-1 .. wired], then wraps to the top.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  rand_q <= RAND_TOP;
        else if (bus.wired_we)                        rand_q <= RAND_TOP;
        else if (rand_q == bus.wired || rand_q == '0) rand_q <= RAND_TOP;
        else                                          rand_q <= rand_q - 1'b1;
    end

    assign bus.random = rand_q;
`else
    logic unused_wired;
    assign unused_wired = ^{bus.wired_we, bus.wired};
    assign bus.random   = '0;
`endif
endmodule

// File: tb/tb_tlb.sv
// Scoreboard bench for tlb: stimulus queues expected observations, a negedge monitor pops and compares.
module tb_tlb;
    import tlb_pkg::*;

    localparam int N  = 16;
    localparam int TW = $clog2(N);
`ifdef TLB_RANDOM_EN
    localparam bit RAND_EN = 1'b1;
`else
    localparam bit RAND_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tlb_if #(.TLBNUM(N)) bus ();
    tlb #(.TLBNUM(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        string          name;
        int             sel;
        logic [127:0]   exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [127:0] sp(logic f, logic [TW-1:0] idx, logic [19:0] pfn,
                                        logic [2:0] c, logic d, logic v);
        return 128'({f, idx, pfn, c, d, v});
    endfunction

    function automatic tlb_entry_t ent(logic [18:0] vpn2, logic [7:0] asid, logic g,
                                       logic [19:0] pfn0, logic [2:0] c0, logic d0, logic v0,
                                       logic [19:0] pfn1, logic [2:0] c1, logic d1, logic v1);
        tlb_entry_t e;
        e.vpn2 = vpn2; e.asid = asid; e.g = g;
        e.p0.pfn = pfn0; e.p0.c = c0; e.p0.d = d0; e.p0.v = v0;
        e.p1.pfn = pfn1; e.p1.c = c1; e.p1.d = d1; e.p1.v = v1;
        return e;
    endfunction

    function automatic logic [127:0] exp_rand(int v);
        return RAND_EN ? 128'(v) : 128'(0);
    endfunction

    function automatic logic [127:0] obs(int sel);
        case (sel)
            0: return 128'({bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v});
            1: return 128'({bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v});
            2: return 128'(bus.random);
            default: return 128'({bus.r_vpn2, bus.r_asid, bus.r_g,
                                  bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0,
                                  bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1});
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t         e;
        logic [127:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
            end
        end
    end

    task automatic chk(string n, int sel, logic [127:0] v);
        exp_t e;
        e.name = n; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.we       = 1'b0;
        bus.wired_we = 1'b0;
    endtask

    task automatic wr(int idx, tlb_entry_t e);
        bus.we      = 1'b1;
        bus.w_index = TW'(idx);
        bus.w_vpn2  = e.vpn2;   bus.w_asid = e.asid;   bus.w_g    = e.g;
        bus.w_pfn0  = e.p0.pfn; bus.w_c0   = e.p0.c;   bus.w_d0   = e.p0.d; bus.w_v0 = e.p0.v;
        bus.w_pfn1  = e.p1.pfn; bus.w_c1   = e.p1.c;   bus.w_d1   = e.p1.d; bus.w_v1 = e.p1.v;
    endtask

    task automatic s0(logic [18:0] vpn, logic odd, logic [7:0] asid);
        bus.s0_vpn = vpn; bus.s0_odd = odd; bus.s0_asid = asid;
    endtask

    task automatic s1(logic [18:0] vpn, logic odd, logic [7:0] asid);
        bus.s1_vpn = vpn; bus.s1_odd = odd; bus.s1_asid = asid;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tlb_entry_t e3, e7, e2, e5a, e5b, e9, e0;
        e3  = ent(19'h12345, 8'h05, 1'b0, 20'hAAAAA, 3'd2, 1'b0, 1'b1, 20'hBBBBB, 3'd5, 1'b1, 1'b0);
        e7  = ent(19'h0ABCD, 8'h33, 1'b1, 20'h77777, 3'd1, 1'b1, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b1);
        e2  = ent(19'h0ABCD, 8'h09, 1'b0, 20'h22222, 3'd3, 1'b0, 1'b1, 20'h33333, 3'd7, 1'b1, 1'b1);
        e5a = ent(19'h55555, 8'h10, 1'b0, 20'h05050, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        e5b = ent(19'h66666, 8'h10, 1'b0, 20'h06060, 3'd4, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        e9  = ent(19'h09999, 8'h01, 1'b1, 20'h09090, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        e0  = ent(19'h00777, 8'h02, 1'b0, 20'h00700, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);

        resetn = 1'b0;
        bus.we = 1'b0; bus.wired_we = 1'b0; bus.wired = '0; bus.r_index = '0;
        wr(0, '0); bus.we = 1'b0;
        s0(19'h0, 1'b0, 8'h0); s1(19'h0, 1'b1, 8'h0);
        cyc(); cyc();
        chk("rst_s0_miss", 0, 128'(0));
        chk("rst_s1_miss", 1, 128'(0));
        chk("rst_random", 2, exp_rand(15));
        chk("rst_read0", 3, 128'(0));
        resetn = 1'b1;

        // Single entry, both halves, ASID mismatch; same-cycle search sees old contents.
        cyc(); wr(3, e3); s0(19'h12345, 1'b0, 8'h05);
        chk("wr3_same_cycle_old", 0, 128'(0));
        cyc(); s1(19'h12345, 1'b1, 8'h05); bus.r_index = 4'd3;
        chk("hit3_even", 0, sp(1'b1, 4'd3, 20'hAAAAA, 3'd2, 1'b0, 1'b1));
        chk("hit3_odd", 1, sp(1'b1, 4'd3, 20'hBBBBB, 3'd5, 1'b1, 1'b0));
        chk("read3", 3, 128'(e3));
        cyc(); s0(19'h12345, 1'b0, 8'h06); s1(19'h12345, 1'b1, 8'h06);
        chk("asid_miss_s0", 0, 128'(0));
        chk("asid_miss_s1", 1, 128'(0));

        // Global entry at 7 and ASID entry at 2 with the same vpn2: lowest index wins.
        cyc(); wr(7, e7);
        cyc(); wr(2, e2);
        cyc(); s0(19'h0ABCD, 1'b0, 8'h09); s1(19'h0ABCD, 1'b1, 8'h01); bus.r_index = 4'd7;
        chk("prio_asid9", 0, sp(1'b1, 4'd2, 20'h22222, 3'd3, 1'b0, 1'b1));
        chk("global_asid1", 1, sp(1'b1, 4'd7, 20'h11111, 3'd0, 1'b0, 1'b1));
        chk("read7_g", 3, 128'(e7));
        cyc(); s0(19'h0ABCD, 1'b0, 8'h33); s1(19'h0ABCD, 1'b1, 8'h09);
        chk("global_asid33", 0, sp(1'b1, 4'd7, 20'h77777, 3'd1, 1'b1, 1'b1));
        chk("prio_asid9_odd", 1, sp(1'b1, 4'd2, 20'h33333, 3'd7, 1'b1, 1'b1));

        // Overwrite idx 5 while searching it.
        cyc(); wr(5, e5a);
        cyc(); wr(5, e5b); s0(19'h55555, 1'b0, 8'h10); s1(19'h66666, 1'b0, 8'h10); bus.r_index = 4'd5;
        chk("ovw_old_s0", 0, sp(1'b1, 4'd5, 20'h05050, 3'd0, 1'b0, 1'b1));
        chk("ovw_old_s1", 1, 128'(0));
        chk("ovw_old_read", 3, 128'(e5a));
        cyc();
        chk("ovw_new_s0", 0, 128'(0));
        chk("ovw_new_s1", 1, sp(1'b1, 4'd5, 20'h06060, 3'd4, 1'b1, 1'b1));
        chk("ovw_new_read", 3, 128'(e5b));

        // wired=4 with wired_we alongside a write; both must take effect.
        cyc(); bus.wired = 4'd4; bus.wired_we = 1'b1; wr(9, e9);
        cyc(); s0(19'h09999, 1'b0, 8'h00);
        chk("rand_load", 2, exp_rand(15));
        chk("we_with_wired_we", 0, sp(1'b1, 4'd9, 20'h09090, 3'd0, 1'b0, 1'b1));
        for (int k = 14; k >= 4; k--) begin
            cyc(); chk($sformatf("rand_dec_%0d", k), 2, exp_rand(k));
        end
        cyc(); chk("rand_wired_wrap", 2, exp_rand(15));
        cyc(); chk("rand_14", 2, exp_rand(14)); bus.wired_we = 1'b1;
        cyc(); chk("rand_midseq_reload", 2, exp_rand(15));

        // wired=2 down to 3, then raise wired above random so zero triggers the wrap.
        cyc(); bus.wired = 4'd2; bus.wired_we = 1'b1;
        for (int k = 15; k >= 3; k--) begin
            cyc(); chk($sformatf("rand_w2_%0d", k), 2, exp_rand(k));
        end
        bus.wired = 4'd8;
        for (int k = 2; k >= 0; k--) begin
            cyc(); chk($sformatf("rand_low_%0d", k), 2, exp_rand(k));
        end
        cyc(); chk("rand_zero_wrap", 2, exp_rand(15));

        // wired = TLBNUM-1 pins random at the top.
        bus.wired = 4'd15; bus.wired_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(); chk($sformatf("rand_pinned_%0d", k), 2, exp_rand(15));
        end

        // Reset mid-operation: outputs clear at once and the pending write is dropped.
        cyc(); wr(0, e0); resetn = 1'b0; s0(19'h12345, 1'b0, 8'h05); s1(19'h0ABCD, 1'b0, 8'h09);
        chk("midrst_s0_clear", 0, 128'(0));
        chk("midrst_s1_clear", 1, 128'(0));
        chk("midrst_random", 2, exp_rand(15));
        cyc(); resetn = 1'b1; wr(0, e0); s0(19'h00777, 1'b0, 8'h02); bus.r_index = 4'd3;
        chk("midrst_write_dropped", 0, 128'(0));
        chk("midrst_read3_clear", 3, 128'(0));
        cyc();
        chk("first_write_after_rst", 0, sp(1'b1, 4'd0, 20'h00700, 3'd0, 1'b0, 1'b1));

        cyc();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
